// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, instruction field positions and
// the fetch FSM state encoding.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluation: decides whether the branch in the IR is taken
// and whether its target is PC-relative.
module br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken,
  output logic       is_rel
);

  logic hit;

  assign hit = |(stat & mm);

  always_comb begin
    taken  = 1'b0;
    is_rel = 1'b0;
    case (opcode)
      OP_BRA: taken = hit;
      OP_BRR: begin
        taken  = hit;
        is_rel = 1'b1;
      end
      OP_BNE: taken = ~hit;
      OP_BNR: begin
        taken  = ~hit;
        is_rel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and program counter for the SISC datapath: owns PC and IR,
// reads instruction memory and resolves conditional branches.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_req,
  input  logic          br_eval,
  input  logic [3:0]    stat,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rdy,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [AW-1:0] pc,
  output logic          fetch_done,
  output logic          busy,
  output logic          halted
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          halted_q, halted_d;

  logic          br_taken, br_rel;
  logic [15:0]   imm;
  logic [AW-1:0] pc_abs, pc_rel;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];
  assign mm     = ir_q[MM_MSB:MM_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];

  // pc already points past the branch, so the relative target adds to pc as-is.
  assign pc_abs = AW'(imm);
  assign pc_rel = pc_q + AW'($signed(imm));

  br_cond u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken),
    .is_rel (br_rel)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q  <= FS_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Memory handshake: imem_rd is the request valid and holds with a stable
  // imem_addr until the first clock edge where imem_rdy is high; that edge is
  // the single transfer. imem_rdy outside a request is ignored.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      FS_IDLE: begin
        // A branch evaluation wins over a same-cycle fetch request.
        if (br_eval) begin
          if (br_taken) pc_d = br_rel ? pc_rel : pc_abs;
        end else if (fetch_req && !halted_q) begin
          state_d = FS_REQ;
        end
      end
      FS_REQ: begin
        if (imem_rdy) begin
          ir_d    = imem_data;
          pc_d    = pc_q + AW'(1);
          state_d = FS_DONE;
          if (imem_data[OPC_MSB:OPC_LSB] == OP_HLT) halted_d = 1'b1;
        end
      end
      FS_DONE: state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
  end

  assign imem_rd    = (state_q == FS_REQ);
  assign busy       = (state_q == FS_REQ);
  assign fetch_done = (state_q == FS_DONE);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign halted     = halted_q;

endmodule
